// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB master with integrated slave decoder.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DECERR = 2'd3
    } apb_state_e;

    typedef logic [2:0] prot_t;

    // A single slave still gets a one-bit index field so that slicing stays legal.
    function automatic int idx_width(input int num_slaves);
        return (num_slaves > 1) ? $clog2(num_slaves) : 1;
    endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational slave-select decoder: 4 KiB-style regions starting at SEL_LSB.
module apb_addr_decode
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_SLAVES = 4,
    parameter int SEL_LSB    = 12
) (
    input  logic [ADDR_WIDTH-1:0]              addr,
    output logic [idx_width(NUM_SLAVES)-1:0]   idx,
    output logic                               hit
);

    localparam int IDX_W  = idx_width(NUM_SLAVES);
    localparam int HI_LSB = SEL_LSB + IDX_W;
    localparam logic [IDX_W:0] NS_W = (IDX_W + 1)'(NUM_SLAVES);

    logic upper_zero;

    assign idx = addr[SEL_LSB +: IDX_W];

    generate
        if (HI_LSB >= ADDR_WIDTH) begin : g_no_upper
            assign upper_zero = 1'b1;
        end else begin : g_upper
            assign upper_zero = ~|addr[ADDR_WIDTH-1:HI_LSB];
        end
    endgenerate

    assign hit = upper_zero && ({1'b0, idx} < NS_W);

endmodule

// File: rtl/apb_master_mux.sv
// APB4 master with a valid/ready command port, N-way PSEL decode, decode-miss
// error and wait-state timeout abort.
//
// state  | meaning
// IDLE   | ready for a command; response pulse (if any) is shown here
// SETUP  | PSEL asserted, PENABLE low, one cycle
// ACCESS | PENABLE high, waiting on the selected slave's PREADY
// DECERR | address hit no slave; error response follows
module apb_master_mux
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int SEL_LSB        = 12,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             PCLK,
    input  logic                             PRESETn,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [ADDR_WIDTH-1:0]            BADDR,
    input  logic                             BWRITE,
    input  logic [DATA_WIDTH-1:0]            BWDATA,
    input  logic [DATA_WIDTH/8-1:0]          BSTRB,
    input  prot_t                            BPROT,
    output logic                             rsp_valid,
    output logic [DATA_WIDTH-1:0]            BRDATA,
    output logic                             BERR,
    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic [NUM_SLAVES-1:0]            PSEL,
    output logic                             PENABLE,
    output logic                             PWRITE,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    output logic [DATA_WIDTH/8-1:0]          PSTRB,
    output prot_t                            PPROT,
    input  logic [NUM_SLAVES-1:0]            PREADY,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]            PSLVERR
);

    localparam int IDX_W = idx_width(NUM_SLAVES);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    apb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       dec_idx;
    logic                   dec_hit;
    logic                   accept;
    logic                   done;
    logic                   abort;
    logic                   timeout_hit;
    logic [CNT_W-1:0]       cnt_q;
    logic                   sel_ready;
    logic                   sel_err;
    logic [DATA_WIDTH-1:0]  sel_rdata;

    apb_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_SLAVES (NUM_SLAVES),
        .SEL_LSB    (SEL_LSB)
    ) u_decode (
        .addr (BADDR),
        .idx  (dec_idx),
        .hit  (dec_hit)
    );

    assign cmd_ready   = (state_q == IDLE);
    assign accept      = cmd_valid && cmd_ready;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

    // PSEL is one-hot while a transfer is open, so it doubles as the mux select.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (PSEL[i]) begin
                sel_ready = PREADY[i];
                sel_err   = PSLVERR[i];
                sel_rdata = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = dec_hit ? SETUP : DECERR;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (sel_ready) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            DECERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            PPROT     <= '0;
            rsp_valid <= 1'b0;
            BRDATA    <= '0;
            BERR      <= 1'b0;
            cnt_q     <= '0;
        end else begin
            rsp_valid <= 1'b0;

            if (accept) begin
                cnt_q  <= '0;
                PADDR  <= BADDR;
                PWRITE <= BWRITE;
                PWDATA <= BWRITE ? BWDATA : '0;
                PSTRB  <= BWRITE ? BSTRB : '0;
                PPROT  <= BPROT;
                if (dec_hit) begin
                    PSEL <= NUM_SLAVES'(1) << dec_idx;
                end
            end

            if (state_q == SETUP) begin
                PENABLE <= 1'b1;
            end

            if ((state_q == ACCESS) && !sel_ready && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end

            // Slave error and timeout both force read data to zero.
            if (done || abort) begin
                PSEL      <= '0;
                PENABLE   <= 1'b0;
                rsp_valid <= 1'b1;
                BERR      <= abort || sel_err;
                BRDATA    <= (done && !sel_err && !PWRITE) ? sel_rdata : '0;
            end

            if (state_q == DECERR) begin
                rsp_valid <= 1'b1;
                BERR      <= 1'b1;
                BRDATA    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_mux.sv
// Scoreboard bench for apb_master_mux with a configurable wait-state slave model.
module tb_apb_master_mux;
    import apb_pkg::*;

    logic         PCLK = 1'b0;
    logic         PRESETn;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [31:0]  BADDR;
    logic         BWRITE;
    logic [31:0]  BWDATA;
    logic [3:0]   BSTRB;
    prot_t        BPROT;
    logic         rsp_valid;
    logic [31:0]  BRDATA;
    logic         BERR;
    logic [31:0]  PADDR;
    logic [3:0]   PSEL;
    logic         PENABLE;
    logic         PWRITE;
    logic [31:0]  PWDATA;
    logic [3:0]   PSTRB;
    prot_t        PPROT;
    logic [3:0]   PREADY;
    logic [127:0] PRDATA;
    logic [3:0]   PSLVERR;

    apb_master_mux #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .NUM_SLAVES     (4),
        .SEL_LSB        (12),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .BADDR     (BADDR),
        .BWRITE    (BWRITE),
        .BWDATA    (BWDATA),
        .BSTRB     (BSTRB),
        .BPROT     (BPROT),
        .rsp_valid (rsp_valid),
        .BRDATA    (BRDATA),
        .BERR      (BERR),
        .PADDR     (PADDR),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PPROT     (PPROT),
        .PREADY    (PREADY),
        .PRDATA    (PRDATA),
        .PSLVERR   (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        berr;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          acc_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          ncyc = 0;
    int          last_acc = -1;
    int          last_rsp = -2;
    int          wait_cfg[4];
    logic [3:0]  err_cfg;
    logic [31:0] rdat_cfg[4];
    int          acc_cnt;
    exp_t        e;
    int          a;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Selected slave raises PREADY after wait_cfg ACCESS cycles; unselected slaves
    // show ready/error/data noise that the master has to ignore.
    always_comb begin
        PREADY  = '0;
        PSLVERR = '0;
        PRDATA  = '0;
        for (int i = 0; i < 4; i++) begin
            PREADY[i]            = PSEL[i] ? (acc_cnt >= wait_cfg[i]) : 1'b1;
            PSLVERR[i]           = err_cfg[i];
            PRDATA[i*32 +: 32]   = rdat_cfg[i];
        end
    end

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            acc_cnt <= 0;
        end else if (!PENABLE) begin
            acc_cnt <= 0;
        end else if ((PSEL != 4'b0) && !(|(PREADY & PSEL))) begin
            acc_cnt <= acc_cnt + 1;
        end
    end

    always @(negedge PCLK) begin
        #2;
        ncyc = ncyc + 1;
        if (PRESETn) begin
            if (cmd_valid && cmd_ready) begin
                acc_q.push_back(ncyc);
                last_acc = ncyc;
            end
            if (PSEL != 4'b0) begin
                chk("psel_onehot", 64'($countones(PSEL)), 64'd1);
                if (!PWRITE) chk("rd_pstrb", {28'd0, PSTRB}, 64'd0);
            end
            if (rsp_valid) begin
                last_rsp = ncyc;
                if (exp_q.size() > 0 && acc_q.size() > 0) begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    chk("rsp_berr", {63'd0, BERR}, {63'd0, e.berr});
                    chk("rsp_rdata", {32'd0, BRDATA}, {32'd0, e.rdata});
                    chk("rsp_latency", 64'(ncyc - a), 64'(e.lat));
                    chk("rsp_cmd_ready", {63'd0, cmd_ready}, 64'd1);
                    chk("rsp_psel_off", {60'd0, PSEL}, 64'd0);
                    chk("rsp_penable_off", {63'd0, PENABLE}, 64'd0);
                end else begin
                    chk("unexp_rsp", {63'd0, rsp_valid}, 64'd0);
                end
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the accept.
    task automatic issue(input logic [31:0] ad, input logic wr, input logic [31:0] wd,
                         input logic [3:0] st, input logic [2:0] pr, input logic push,
                         input logic eb, input logic [31:0] er, input int el);
        int budget;
        exp_t x;
        cmd_valid = 1'b1;
        BADDR     = ad;
        BWRITE    = wr;
        BWDATA    = wd;
        BSTRB     = st;
        BPROT     = pr;
        if (push) begin
            x.berr  = eb;
            x.rdata = er;
            x.lat   = el;
            exp_q.push_back(x);
        end
        budget = 0;
        while (!cmd_ready && budget < 50) begin
            @(negedge PCLK);
            budget++;
        end
        if (!cmd_ready) chk("accept_timeout", {63'd0, cmd_ready}, 64'd1);
        @(posedge PCLK);
        @(negedge PCLK);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 100) begin
            @(negedge PCLK);
            #3;
            budget++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        @(negedge PCLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        BADDR     = '0;
        BWRITE    = 1'b0;
        BWDATA    = '0;
        BSTRB     = '0;
        BPROT     = '0;
        err_cfg   = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            wait_cfg[i] = 0;
            rdat_cfg[i] = 32'hA0A0_0000 + 32'(i);
        end
        rdat_cfg[1] = 32'h1234_5678;

        repeat (2) @(negedge PCLK);
        #1;
        chk("rst_psel", {60'd0, PSEL}, 64'd0);
        chk("rst_penable", {63'd0, PENABLE}, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_berr", {63'd0, BERR}, 64'd0);
        chk("rst_brdata", {32'd0, BRDATA}, 64'd0);
        chk("rst_paddr", {32'd0, PADDR}, 64'd0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        #2;
        chk("post_rst_ready", {63'd0, cmd_ready}, 64'd1);
        @(negedge PCLK);

        // Zero-wait write to slave 2; PRDATA noise must not reach BRDATA.
        issue(32'h0000_2004, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b010, 1'b1, 1'b0, 32'h0, 3);
        #2;
        chk("wr_setup_psel", {60'd0, PSEL}, 64'h4);
        chk("wr_setup_penable", {63'd0, PENABLE}, 64'd0);
        chk("wr_paddr", {32'd0, PADDR}, 64'h0000_2004);
        chk("wr_pwdata", {32'd0, PWDATA}, 64'hDEAD_BEEF);
        chk("wr_pstrb", {60'd0, PSTRB}, 64'hF);
        chk("wr_pprot", {61'd0, PPROT}, 64'h2);
        chk("wr_pwrite", {63'd0, PWRITE}, 64'd1);
        @(negedge PCLK);
        #2;
        chk("wr_access_penable", {63'd0, PENABLE}, 64'd1);
        chk("wr_access_psel", {60'd0, PSEL}, 64'h4);
        drain();

        // Read from slave 1 with three wait states.
        wait_cfg[1] = 3;
        issue(32'h0000_1010, 1'b0, 32'h0, 4'h0, 3'b000, 1'b1, 1'b0, 32'h1234_5678, 6);
        drain();

        // Decode miss above the populated range.
        issue(32'h0001_0000, 1'b0, 32'h0, 4'h0, 3'b000, 1'b1, 1'b1, 32'h0, 2);
        #2;
        chk("miss_psel_c1", {60'd0, PSEL}, 64'd0);
        @(negedge PCLK);
        #2;
        chk("miss_psel_c2", {60'd0, PSEL}, 64'd0);
        drain();

        // Slave 0 never ready: 16-cycle timeout, then a back-to-back write.
        wait_cfg[0] = 1000;
        issue(32'h0000_0000, 1'b0, 32'h0, 4'h0, 3'b001, 1'b1, 1'b1, 32'h0, 18);
        issue(32'h0000_2000, 1'b1, 32'h0000_55AA, 4'h3, 3'b000, 1'b1, 1'b0, 32'h0, 3);
        chk("b2b_accept_cycle", 64'(last_acc), 64'(last_rsp));
        drain();

        // Slave 3 signals PSLVERR on a read.
        issue(32'h0000_3008, 1'b0, 32'h0, 4'h0, 3'b000, 1'b1, 1'b1, 32'h0, 3);
        drain();

        // Asynchronous reset in the middle of ACCESS.
        wait_cfg[1] = 1000;
        issue(32'h0000_1000, 1'b0, 32'h0, 4'h0, 3'b000, 1'b0, 1'b0, 32'h0, 0);
        @(negedge PCLK);
        @(negedge PCLK);
        #3;
        PRESETn = 1'b0;
        #1;
        chk("arst_psel", {60'd0, PSEL}, 64'd0);
        chk("arst_penable", {63'd0, PENABLE}, 64'd0);
        chk("arst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        acc_q.delete();
        @(negedge PCLK);
        PRESETn = 1'b1;
        #2;
        chk("arst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        @(negedge PCLK);
        wait_cfg[1] = 0;
        issue(32'h0000_1000, 1'b0, 32'h0, 4'h0, 3'b000, 1'b1, 1'b0, 32'h1234_5678, 3);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/apb_master_mux.md
Name: apb_master_mux

Overview:
- Parametrised next-generation APB master with an integrated N-way slave-select decoder.
- Accepts commands on a valid/ready front end and runs APB4 SETUP/ACCESS transfers, including PSTRB and PPROT.
- Drives one of NUM_SLAVES PSEL lines and muxes that slave's PREADY/PRDATA/PSLVERR back.
- Adds two error paths: a decode-miss error response and a wait-state timeout abort.

Parameters:
ADDR_WIDTH, 32, width of BADDR/PADDR
DATA_WIDTH, 32, width of data buses; must be 8, 16 or 32
NUM_SLAVES, 4, number of PSEL outputs (1..16)
SEL_LSB, 12, lowest address bit of the slave index field (4 KiB regions)
TIMEOUT_CYCLES, 16, maximum ACCESS-phase cycles with PREADY low before abort; 0 disables the timeout

Ports:
PCLK  in  1  clock
PRESETn  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  master can accept a command
BADDR  in  ADDR_WIDTH  command address
BWRITE  in  1  1=write, 0=read
BWDATA  in  DATA_WIDTH  write data
BSTRB  in  DATA_WIDTH/8  write byte strobes
BPROT  in  3  protection attributes
rsp_valid  out  1  one-cycle response pulse
BRDATA  out  DATA_WIDTH  read data, valid with rsp_valid
BERR  out  1  error flag, valid with rsp_valid
PADDR  out  ADDR_WIDTH  APB address
PSEL  out  NUM_SLAVES  one-hot slave select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PWDATA  out  DATA_WIDTH  APB write data
PSTRB  out  DATA_WIDTH/8  APB strobes
PPROT  out  3  APB protection
PREADY  in  NUM_SLAVES  per-slave ready
PRDATA  in  NUM_SLAVES*DATA_WIDTH  per-slave read data; slave i occupies [i*DATA_WIDTH +: DATA_WIDTH]
PSLVERR  in  NUM_SLAVES  per-slave error

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - State goes to IDLE.
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, rsp_valid, BRDATA and BERR all clear to 0.
  - The timeout counter clears to 0.
  - cmd_ready = 1 after reset is released.
- FSM states: IDLE, SETUP, ACCESS, DECERR.
- cmd_ready = (state == IDLE). A command is accepted on cmd_valid && cmd_ready.
- On accept, the command fields are registered and the slave index is computed as idx = BADDR[SEL_LSB +: clog2(NUM_SLAVES)].
- Decode hit requires both:
  - all BADDR bits above the index field are 0, and
  - idx < NUM_SLAVES.
- Decode hit → next state SETUP:
  - PSEL[idx] = 1, PENABLE = 0.
  - PADDR, PWRITE, PWDATA, PSTRB and PPROT are driven from the registered command.
  - On reads, PWDATA = 0 and PSTRB = 0.
- Decode miss → next state DECERR:
  - No PSEL is asserted.
  - The following cycle: rsp_valid = 1, BERR = 1, BRDATA = 0, then return to IDLE.
- SETUP always moves to ACCESS after exactly one cycle: PENABLE = 1, and PSEL and all P* outputs stay stable.
- ACCESS:
  - Sampled each cycle on PREADY[idx].
  - While PREADY[idx] = 0, the counter increments.
  - If TIMEOUT_CYCLES ≠ 0 and the counter reaches TIMEOUT_CYCLES, the transfer aborts:
    - PSEL and PENABLE drop to 0.
    - rsp_valid = 1, BERR = 1, BRDATA = 0.
    - Return to IDLE.
  - When PREADY[idx] = 1 (including on the same cycle the counter would expire, since ready wins):
    - PSEL and PENABLE drop to 0.
    - rsp_valid = 1, BERR = PSLVERR[idx].
    - BRDATA = the PRDATA slice of slave idx on reads and 0 on writes. BRDATA is 0 whenever BERR = 1.
    - Return to IDLE.
- rsp_valid is high for exactly one cycle, and that cycle is already IDLE. cmd_ready = 1 in the same cycle, so a new command can be accepted there.
- PREADY, PRDATA and PSLVERR of unselected slaves are ignored.
- Minimum latency, accept to rsp_valid:
  - Zero-wait transfer: 3 cycles.
  - Decode miss: 2 cycles.
- Throughput: one transfer per 3 cycles.
- The counter clears on every accept. It is a saturating counter of width clog2(TIMEOUT_CYCLES+1).
- PADDR is held after the transfer; the other P* data outputs may also hold. PSEL is never multi-hot.

Decomposition:
- Package apb_pkg holds:
  - the state enum apb_state_e {IDLE, SETUP, ACCESS, DECERR},
  - the prot_t typedef (logic [2:0]),
  - a function computing the index width from NUM_SLAVES.
- Sub-module apb_addr_decode (combinational):
  - Inputs: address.
  - Outputs: idx and hit.
  - Parametrised by ADDR_WIDTH, NUM_SLAVES and SEL_LSB.
- FSM, counter and response mux stay in apb_master_mux.

Test Plan:
- Write 0xDEADBEEF to 0x0000_2004, BSTRB=0xF, slave 2 ready in ACCESS:
  - PSEL=4'b0100 with PENABLE=0 for 1 cycle, then PENABLE=1.
  - rsp_valid 3 cycles after accept, BERR=0.
- Read from 0x0000_1010, slave 1 holds PREADY=0 for 3 ACCESS cycles, PRDATA=0x12345678:
  - rsp_valid 6 cycles after accept, BRDATA=0x12345678, BERR=0.
- Read from 0x0001_0000 (above range):
  - PSEL stays 0.
  - rsp_valid 2 cycles after accept, BERR=1, BRDATA=0.
- Slave 0 never asserts PREADY, TIMEOUT_CYCLES=16:
  - Abort after 16 ACCESS cycles, PSEL drops to 0.
  - rsp_valid with BERR=1.
  - Next command is accepted on the same cycle.
- Slave 3 returns PSLVERR=1 with PREADY=1 on a read:
  - BERR=1, BRDATA=0.
- PRESETn asserted during ACCESS:
  - PSEL, PENABLE and rsp_valid go to 0 immediately, without waiting for a clock edge.
  - After release, cmd_ready=1 and the state is IDLE.
